// File: rtl/dm_responder_pkg.sv
// Shared definitions for the wait-state data-memory responder.
// Holds the FSM state encoding, default geometry/latency, the byte-lane
// width and a small range-check helper used by the responder core.
package dm_responder_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int DEF_LATENCY     = 2;
    localparam int DEF_DEPTH_WORDS = 1024;
    localparam int LANE_W          = 8;
    localparam int NUM_LANES       = 4;
    localparam int WORD_W          = 32;
    localparam int CNT_W           = 4;

    // True when a word index addresses a word that physically exists.
    function automatic logic addr_in_range(input logic [29:0] word_idx,
                                           input int          depth_words);
        logic [31:0] depth_u;
        depth_u = $unsigned(depth_words);
        return ({2'b00, word_idx} < depth_u);
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Load/store port between the M stage and the data-memory responder.
// master (pipeline side) drives Req, WriteEnabled, Addr, Bit_Type,
// WriteData and PC; slave (responder) drives ReadData, Ready, AddrErr,
// Stall and the write-log record (log_valid/log_pc/log_addr/log_data),
// which a simulation environment turns into "@PC: *Addr <= word" lines.
interface dm_responder_if;
    import dm_responder_pkg::*;

    logic                 Req;
    logic                 WriteEnabled;
    logic [WORD_W-1:0]    Addr;
    logic [NUM_LANES-1:0] Bit_Type;
    logic [WORD_W-1:0]    WriteData;
    logic [WORD_W-1:0]    PC;
    logic [WORD_W-1:0]    ReadData;
    logic                 Ready;
    logic                 AddrErr;
    logic                 Stall;
    logic                 log_valid;
    logic [WORD_W-1:0]    log_pc;
    logic [WORD_W-1:0]    log_addr;
    logic [WORD_W-1:0]    log_data;

    modport master (
        output Req, WriteEnabled, Addr, Bit_Type, WriteData, PC,
        input  ReadData, Ready, AddrErr, Stall,
        input  log_valid, log_pc, log_addr, log_data
    );

    modport slave (
        input  Req, WriteEnabled, Addr, Bit_Type, WriteData, PC,
        output ReadData, Ready, AddrErr, Stall,
        output log_valid, log_pc, log_addr, log_data
    );

endinterface

// File: rtl/dm_responder_be_merge.sv
// Byte-lane merge: each lane of merged comes from new_word when its
// lane_en bit is set, otherwise from old_word.
// Ports: old_word (current memory word), new_word (lane-positioned store
// data), lane_en (byte enables, bit i = bits [8i+7:8i]), merged (result).
module be_merge
    import dm_responder_pkg::*;
(
    input  logic [WORD_W-1:0]    old_word,
    input  logic [WORD_W-1:0]    new_word,
    input  logic [NUM_LANES-1:0] lane_en,
    output logic [WORD_W-1:0]    merged
);

    // Per-lane select between old and new byte
    always_comb begin
        merged = old_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_en[i]) begin
                merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
            end else begin
                merged[i*LANE_W +: LANE_W] = old_word[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Wait-state data-memory responder for the M-stage load/store port.
// Accepts one request at a time, stalls the pipeline for LATENCY+1
// cycles, performs byte-lane-masked stores and returns raw read words.
// Ports: clk, reset (synchronous, active-high), bus (slave side of
// dm_responder_if carrying request, response, Stall and write log).
// Parameters: LATENCY (1..15 wait cycles), DEPTH_WORDS (memory words).
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int LATENCY     = DEF_LATENCY,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
)
(
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_W-1:0]     cnt_r;

    logic                 we_r;
    logic [WORD_W-1:0]    addr_r;
    logic [NUM_LANES-1:0] be_r;
    logic [WORD_W-1:0]    wdata_r;
    logic [WORD_W-1:0]    pc_r;

    logic [WORD_W-1:0]    mem_r [DEPTH_WORDS];

    logic [WORD_W-1:0]    read_data_r;
    logic                 ready_r;
    logic                 addr_err_r;
    logic                 log_valid_r;
    logic [WORD_W-1:0]    log_pc_r;
    logic [WORD_W-1:0]    log_addr_r;
    logic [WORD_W-1:0]    log_data_r;

    logic                 stall_s;
    logic                 in_range_s;
    logic [IDX_W-1:0]     idx_s;
    logic [WORD_W-1:0]    old_word_s;
    logic [WORD_W-1:0]    merged_s;
    logic                 access_s;
    logic                 do_write_s;

    assign in_range_s = addr_in_range(addr_r[31:2], DEPTH_WORDS);
    assign idx_s      = addr_r[IDX_W+1:2];
    // Out-of-range indices never reach the array, even for non-power-of-two depths
    assign old_word_s = in_range_s ? mem_r[idx_s] : {WORD_W{1'b0}};
    // The access happens on the edge that leaves the last WAIT cycle
    assign access_s   = (state_r == S_WAIT) && (cnt_r == {CNT_W{1'b0}});
    // An all-zero lane mask completes like any store but touches nothing
    assign do_write_s = access_s && we_r && in_range_s && (|be_r);

    be_merge u_be_merge (
        .old_word (old_word_s),
        .new_word (wdata_r),
        .lane_en  (be_r),
        .merged   (merged_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; RESP never accepts the still-asserted Req
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.Req) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = S_RESP;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_RESP: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Stall: combinational from state and Req, forced low during reset
    always_comb begin
        stall_s = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE:  stall_s = bus.Req;
                S_WAIT:  stall_s = 1'b1;
                S_RESP:  stall_s = 1'b0;
                default: stall_s = 1'b0;
            endcase
        end
    end

    // Request capture on acceptance and wait-cycle countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            we_r    <= 1'b0;
            addr_r  <= {WORD_W{1'b0}};
            be_r    <= {NUM_LANES{1'b0}};
            wdata_r <= {WORD_W{1'b0}};
            pc_r    <= {WORD_W{1'b0}};
        end else if ((state_r == S_IDLE) && bus.Req) begin
            cnt_r   <= CNT_LOAD;
            we_r    <= bus.WriteEnabled;
            addr_r  <= bus.Addr;
            be_r    <= bus.Bit_Type;
            wdata_r <= bus.WriteData;
            pc_r    <= bus.PC;
        end else if ((state_r == S_WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r   <= cnt_r;
        end
    end

    // Memory array: cleared by reset, which also cancels a same-edge write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= {WORD_W{1'b0}};
            end
        end else if (do_write_s) begin
            mem_r[idx_s] <= merged_s;
        end else begin
            mem_r[idx_s] <= mem_r[idx_s];
        end
    end

    // Registered response and write-log record, all valid in RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_r <= {WORD_W{1'b0}};
            ready_r     <= 1'b0;
            addr_err_r  <= 1'b0;
            log_valid_r <= 1'b0;
            log_pc_r    <= {WORD_W{1'b0}};
            log_addr_r  <= {WORD_W{1'b0}};
            log_data_r  <= {WORD_W{1'b0}};
        end else begin
            ready_r     <= access_s;
            addr_err_r  <= access_s && !in_range_s;
            log_valid_r <= do_write_s;
            if (access_s && !in_range_s) begin
                read_data_r <= {WORD_W{1'b0}};
            end else if (access_s && !we_r) begin
                read_data_r <= mem_r[idx_s];
            end else begin
                read_data_r <= read_data_r;
            end
            if (do_write_s) begin
                log_pc_r   <= pc_r;
                log_addr_r <= addr_r;
                log_data_r <= merged_s;
            end else begin
                log_pc_r   <= log_pc_r;
                log_addr_r <= log_addr_r;
                log_data_r <= log_data_r;
            end
        end
    end

    assign bus.Stall     = stall_s;
    assign bus.ReadData  = read_data_r;
    assign bus.Ready     = ready_r;
    assign bus.AddrErr   = addr_err_r;
    assign bus.log_valid = log_valid_r;
    assign bus.log_pc    = log_pc_r;
    assign bus.log_addr  = log_addr_r;
    assign bus.log_data  = log_data_r;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with LATENCY=2 for the
// data-path cases and one with LATENCY=1 for the held-Req cadence.
module tb_dm_responder;
    import dm_responder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   log_count = 0;
    logic [31:0] last_log_data = 32'h0;

    always #5 clk = ~clk;

    dm_responder_if bus ();
    dm_responder_if bus2 ();

    dm_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dm_responder #(.LATENCY(1), .DEPTH_WORDS(1024)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    // Simulation write log for the main instance
    always @(negedge clk) begin
        if (bus.log_valid === 1'b1) begin
            $display("@%08h: *%08h <= %08h", bus.log_pc, bus.log_addr, bus.log_data);
            log_count++;
            last_log_data = bus.log_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", tag, act, exp);
        end
    endtask

    // One complete access; entered and left at posedge+1 with the DUT idle.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic err, output int stalls, output int rc);
        bus.Req = 1'b1; bus.WriteEnabled = we; bus.Addr = addr;
        bus.Bit_Type = be; bus.WriteData = wd; bus.PC = 32'h0040_0000 + addr;
        stalls = 0; rc = -1; rd = 32'h0; err = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.Stall === 1'b1) stalls++;
            if (bus.Ready === 1'b1) begin
                rc = c; rd = bus.ReadData; err = bus.AddrErr;
                break;
            end
            @(posedge clk); #1;
        end
        bus.Req = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        err;
    int          stalls, rc, logs_before;
    logic        ready_seen;
    logic [11:0] ready_seq, stall_seq, exp_ready, exp_stall;
    int          ready_cnt;

    initial begin
        reset = 1'b1;
        bus.Req = 1'b1; bus.WriteEnabled = 1'b0; bus.Addr = 32'h0;
        bus.Bit_Type = 4'h0; bus.WriteData = 32'h0; bus.PC = 32'h0;
        bus2.Req = 1'b0; bus2.WriteEnabled = 1'b0; bus2.Addr = 32'h0;
        bus2.Bit_Type = 4'hF; bus2.WriteData = 32'h0; bus2.PC = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_stall_forced", {31'h0, bus.Stall}, 32'h0);
        check_eq("rst_ready", {31'h0, bus.Ready}, 32'h0);
        check_eq("rst_addrerr", {31'h0, bus.AddrErr}, 32'h0);
        check_eq("rst_readdata", bus.ReadData, 32'h0);
        bus.Req = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_stall", {31'h0, bus.Stall}, 32'h0);

        // Word store then load
        access(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, rd, err, stalls, rc);
        check_eq("st_stalls", stalls, 32'd3);
        check_eq("st_ready_cycle", rc, 32'd3);
        check_eq("st_addrerr", {31'h0, err}, 32'h0);
        check_eq("st_log_count", log_count, 32'd1);
        check_eq("st_log_data", last_log_data, 32'hDEADBEEF);
        access(1'b0, 32'h10, 4'b0001, 32'h0, rd, err, stalls, rc);
        check_eq("ld_stalls", stalls, 32'd3);
        check_eq("ld_ready_cycle", rc, 32'd3);
        check_eq("ld_data", rd, 32'hDEADBEEF);
        check_eq("ld_addrerr", {31'h0, err}, 32'h0);

        // Empty-lane store
        logs_before = log_count;
        access(1'b1, 32'h10, 4'b0000, 32'h11223344, rd, err, stalls, rc);
        check_eq("empty_ready_cycle", rc, 32'd3);
        check_eq("empty_no_log", log_count, logs_before);
        access(1'b0, 32'h10, 4'b1111, 32'h0, rd, err, stalls, rc);
        check_eq("empty_word_kept", rd, 32'hDEADBEEF);

        // Byte merge into lane 2
        access(1'b1, 32'h10, 4'b0100, 32'h00AA0000, rd, err, stalls, rc);
        check_eq("merge_log_data", last_log_data, 32'hDEAABEEF);
        access(1'b0, 32'h10, 4'b0000, 32'h0, rd, err, stalls, rc);
        check_eq("merge_load", rd, 32'hDEAABEEF);

        // Out of range store, then load of 0x0
        logs_before = log_count;
        access(1'b1, 32'h1000, 4'b1111, 32'hCAFEF00D, rd, err, stalls, rc);
        check_eq("oor_ready_cycle", rc, 32'd3);
        check_eq("oor_addrerr", {31'h0, err}, 32'h1);
        check_eq("oor_readdata", rd, 32'h0);
        check_eq("oor_no_log", log_count, logs_before);
        access(1'b0, 32'h0, 4'b1111, 32'h0, rd, err, stalls, rc);
        check_eq("oor_load0", rd, 32'h0);
        check_eq("oor_load0_err", {31'h0, err}, 32'h0);

        // Reset in the first WAIT cycle of a store
        logs_before = log_count;
        bus.Req = 1'b1; bus.WriteEnabled = 1'b1; bus.Addr = 32'h20;
        bus.Bit_Type = 4'b1111; bus.WriteData = 32'h12345678;
        @(posedge clk); #1;
        reset = 1'b1; bus.Req = 1'b0;
        #1;
        check_eq("midrst_stall", {31'h0, bus.Stall}, 32'h0);
        ready_seen = 1'b0;
        @(posedge clk); #1;
        ready_seen = ready_seen | bus.Ready;
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            ready_seen = ready_seen | bus.Ready;
        end
        check_eq("midrst_no_ready", {31'h0, ready_seen}, 32'h0);
        check_eq("midrst_no_log", log_count, logs_before);
        access(1'b0, 32'h20, 4'b1111, 32'h0, rd, err, stalls, rc);
        check_eq("midrst_idle_accept", rc, 32'd3);
        check_eq("midrst_load20", rd, 32'h0);
        access(1'b0, 32'h10, 4'b1111, 32'h0, rd, err, stalls, rc);
        check_eq("midrst_mem_cleared", rd, 32'h0);

        // Held Req on the LATENCY=1 instance
        bus2.Req = 1'b1;
        ready_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            ready_seq[c] = bus2.Ready;
            stall_seq[c] = bus2.Stall;
            if (bus2.Ready === 1'b1) ready_cnt++;
            exp_ready[c] = ((c % 3) == 2);
            exp_stall[c] = ((c % 3) != 2);
            @(posedge clk); #1;
        end
        bus2.Req = 1'b0;
        check_eq("held_ready_seq", {20'h0, ready_seq}, {20'h0, exp_ready});
        check_eq("held_stall_seq", {20'h0, stall_seq}, {20'h0, exp_stall});
        check_eq("held_ready_count", ready_cnt, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
